// File: rtl/ins_fetch.sv
// Serial-loaded 16 x 11-bit instruction store with a registered fetch port.
// The program is shifted in LSB-first while in LOAD, then words are fetched by PC_CURR in RUN.
module ins_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_mode,
  input  logic        ld_valid,
  input  logic        ld_data,
  output logic        ld_ready,
  output logic        load_done,
  input  logic [3:0]  PC_CURR,
  output logic [10:0] INS,
  output logic        ins_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state_reg, state_next;
  logic [10:0] mem_reg [16];
  logic [10:0] shift_reg, shift_next;
  logic [10:0] shifted;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  word_cnt_reg, word_cnt_next;
  logic [10:0] ins_reg, ins_next;
  logic        ins_valid_reg, ins_valid_next;
  logic        load_done_reg, load_done_next;
  logic        mem_we;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  assign shifted = {ld_data, shift_reg[10:1]};

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    word_cnt_next  = word_cnt_reg;
    ins_next       = ins_reg;
    ins_valid_next = ins_valid_reg;
    load_done_next = 1'b0;
    mem_we         = 1'b0;
    case (state_reg)
      IDLE: begin
        shift_next    = '0;
        bit_cnt_next  = '0;
        word_cnt_next = '0;
        state_next    = load_mode ? LOAD : RUN;
      end
      LOAD: begin
        // Dropping load_mode aborts the load and takes priority over a pending bit.
        if (!load_mode) begin
          state_next    = IDLE;
          shift_next    = '0;
          bit_cnt_next  = '0;
          word_cnt_next = '0;
        end else if (ld_valid) begin
          if (bit_cnt_reg == 4'd10) begin
            mem_we        = 1'b1;
            shift_next    = '0;
            bit_cnt_next  = '0;
            word_cnt_next = word_cnt_reg + 4'd1;
            if (word_cnt_reg == 4'd15) begin
              state_next     = RUN;
              load_done_next = 1'b1;
            end
          end else begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      RUN: begin
        if (load_mode) begin
          state_next     = LOAD;
          shift_next     = '0;
          bit_cnt_next   = '0;
          word_cnt_next  = '0;
          ins_valid_next = 1'b0;
        end else begin
          ins_next       = mem_reg[PC_CURR];
          ins_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      word_cnt_reg  <= '0;
      ins_reg       <= '0;
      ins_valid_reg <= 1'b0;
      load_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      word_cnt_reg  <= word_cnt_next;
      ins_reg       <= ins_next;
      ins_valid_reg <= ins_valid_next;
      load_done_reg <= load_done_next;
    end
  end

  // One register per word so reset can clear the whole store at once.
  for (genvar gi = 0; gi < 16; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (mem_we && (word_cnt_reg == 4'(gi))) begin
        mem_reg[gi] <= shifted;
      end
    end
  end

  assign ld_ready  = (state_reg == LOAD);
  assign load_done = load_done_reg;
  assign INS       = ins_reg;
  assign ins_valid = ins_valid_reg;

endmodule
